xillybus_mem_port: RTL and testbench

Parametrised successor to the fixed 8-bit, 32-entry seekable memory stream on the core's user side. It owns the host-visible memory and adds:
- configurable data width and depth;
- wrap or end-of-file addressing mode;
- a second application-side port with collision handling;
- sticky error flags and a host-write dirty flag.
It sits between xillybus_core's user_*_mem_* signals and application logic, in the bus_clk_w domain.

---
 rtl/xillybus_mem_port_if.sv | 48 ++++
 rtl/xillybus_mem_port.sv | 130 +++++++++++++
 tb/tb_xillybus_mem_port.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xillybus_mem_port_if.sv
// Host (xillybus_core user_*_mem_*) and application-side signals of xillybus_mem_port.
// slave: the memory port itself; master: the core/application driving it.
interface xillybus_mem_port_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] user_mem_addr_w;
   logic              user_mem_addr_update_w;
   logic              user_w_mem_wren_w;
   logic [DATA_W-1:0] user_w_mem_data_w;
   logic              user_w_mem_open_w;
   logic              user_w_mem_full_w;
   logic              user_r_mem_rden_w;
   logic [DATA_W-1:0] user_r_mem_data_w;
   logic              user_r_mem_empty_w;
   logic              user_r_mem_eof_w;
   logic              user_r_mem_open_w;
   logic              app_en;
   logic              app_we;
   logic [ADDR_W-1:0] app_addr;
   logic [DATA_W-1:0] app_wdata;
   logic [DATA_W-1:0] app_rdata;
   logic              app_dirty;
   logic              app_dirty_clr;
   logic              app_collision;
   logic [1:0]        err_flags;
   logic              err_clr;

   modport slave (
      input  user_mem_addr_w, user_mem_addr_update_w,
      input  user_w_mem_wren_w, user_w_mem_data_w, user_w_mem_open_w,
      output user_w_mem_full_w,
      input  user_r_mem_rden_w, user_r_mem_open_w,
      output user_r_mem_data_w, user_r_mem_empty_w, user_r_mem_eof_w,
      input  app_en, app_we, app_addr, app_wdata, app_dirty_clr, err_clr,
      output app_rdata, app_dirty, app_collision, err_flags
   );

   modport master (
      output user_mem_addr_w, user_mem_addr_update_w,
      output user_w_mem_wren_w, user_w_mem_data_w, user_w_mem_open_w,
      input  user_w_mem_full_w,
      output user_r_mem_rden_w, user_r_mem_open_w,
      input  user_r_mem_data_w, user_r_mem_empty_w, user_r_mem_eof_w,
      output app_en, app_we, app_addr, app_wdata, app_dirty_clr, err_clr,
      input  app_rdata, app_dirty, app_collision, err_flags
   );
endinterface

// File: rtl/xillybus_mem_port.sv
// xillybus_mem_port: host-seekable memory stream with a second application port,
// wrap or end-of-file addressing, write-collision reporting, sticky error flags and a
// host-write dirty flag. Single clock domain (bus_clk_w).
module xillybus_mem_port #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned WRAP   = 1
) (
   input logic                bus_clk_w,
   input logic                bus_rst_w,
   xillybus_mem_port_if.slave bus
);

   localparam logic [ADDR_W:0] LP_DEPTH = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] LP_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] LP_LAST  = LP_DEPTH - LP_ONE;
   // Where the pointer lands past the last word or after an out-of-range seek
   localparam logic [ADDR_W:0] LP_PARK  = (WRAP != 0) ? '0 : LP_DEPTH;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_ptr;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_app_rdata;
   logic              r_dirty;
   logic              r_coll;
   logic [1:0]        r_err;
   logic [1:0]        r_open;

   logic [ADDR_W:0]   w_ptr_nxt;
   logic [ADDR_W:0]   w_addr_ext;
   logic              w_seek_bad;
   logic [ADDR_W:0]   w_seek_tgt;
   logic              w_open_rise;
   logic [ADDR_W:0]   w_ea;
   logic [ADDR_W-1:0] w_ea_idx;
   logic              w_ea_ok;
   logic [ADDR_W:0]   w_ea_inc;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_app_ok;
   logic              w_app_wr;
   logic              w_app_rd;
   logic              w_coll;
   logic [1:0]        w_err_new;
   logic              w_at_end;

   assign w_addr_ext  = {1'b0, bus.user_mem_addr_w};
   assign w_seek_bad  = bus.user_mem_addr_update_w && (w_addr_ext >= LP_DEPTH);
   assign w_seek_tgt  = w_seek_bad ? LP_PARK : w_addr_ext;
   assign w_open_rise = |({bus.user_r_mem_open_w, bus.user_w_mem_open_w} & ~r_open);

   // A seek bypasses the pointer; a fresh open acts as a seek to 0 unless a real seek is present
   assign w_ea     = bus.user_mem_addr_update_w ? w_seek_tgt : (w_open_rise ? '0 : r_ptr);
   assign w_ea_idx = w_ea[ADDR_W-1:0];
   assign w_ea_ok  = (w_ea < LP_DEPTH);
   assign w_ea_inc = (w_ea == LP_LAST) ? LP_PARK : (w_ea + LP_ONE);

   // Full/empty are judged at the effective address so a same-cycle seek takes effect
   assign w_wr_acc = bus.user_w_mem_wren_w && w_ea_ok;
   assign w_rd_acc = bus.user_r_mem_rden_w && w_ea_ok;

   assign w_app_ok = ({1'b0, bus.app_addr} < LP_DEPTH);
   assign w_app_wr = bus.app_en && bus.app_we && w_app_ok;
   assign w_app_rd = bus.app_en && !bus.app_we;
   assign w_coll   = w_app_wr && w_wr_acc && ({1'b0, bus.app_addr} == w_ea);

   assign w_err_new = {bus.user_r_mem_rden_w && !w_ea_ok,
                       w_seek_bad || (bus.user_w_mem_wren_w && !w_ea_ok)};

   assign w_at_end = (WRAP == 0) && (r_ptr == LP_DEPTH);

   assign bus.user_w_mem_full_w  = w_at_end;
   assign bus.user_r_mem_empty_w = w_at_end;
   assign bus.user_r_mem_eof_w   = w_at_end;
   assign bus.user_r_mem_data_w  = r_rdata;
   assign bus.app_rdata          = r_app_rdata;
   assign bus.app_dirty          = r_dirty;
   assign bus.app_collision      = r_coll;
   assign bus.err_flags          = r_err;

   // Next pointer: advance after an accepted access, else seek, else rewind on open
   always_comb begin
      w_ptr_nxt = r_ptr;
      if (w_wr_acc || w_rd_acc) begin
         w_ptr_nxt = w_ea_inc;
      end else if (bus.user_mem_addr_update_w) begin
         w_ptr_nxt = w_seek_tgt;
      end else if (w_open_rise) begin
         w_ptr_nxt = '0;
      end
   end

   // Pointer, read data, and status flags
   always_ff @(posedge bus_clk_w or posedge bus_rst_w) begin
      if (bus_rst_w) begin
         r_ptr       <= '0;
         r_rdata     <= '0;
         r_app_rdata <= '0;
         r_dirty     <= 1'b0;
         r_coll      <= 1'b0;
         r_err       <= 2'b00;
         r_open      <= 2'b00;
      end else begin
         r_ptr  <= w_ptr_nxt;
         r_open <= {bus.user_r_mem_open_w, bus.user_w_mem_open_w};
         // Both reads sample the array before this edge's writes land: read-before-write
         if (w_rd_acc) begin
            r_rdata <= r_mem[w_ea_idx];
         end
         if (w_app_rd) begin
            r_app_rdata <= w_app_ok ? r_mem[bus.app_addr] : '0;
         end
         r_coll  <= w_coll;
         r_dirty <= w_wr_acc || (r_dirty && !bus.app_dirty_clr);
         r_err   <= (bus.err_clr ? 2'b00 : r_err) | w_err_new;
      end
   end

   // Storage array, not reset; the host wins a same-address write collision
   always_ff @(posedge bus_clk_w) begin
      if (w_wr_acc) begin
         r_mem[w_ea_idx] <= bus.user_w_mem_data_w;
      end
      if (w_app_wr && !w_coll) begin
         r_mem[bus.app_addr] <= bus.app_wdata;
      end
   end

endmodule

// File: tb/tb_xillybus_mem_port.sv
// Bench for xillybus_mem_port: two instances (8-bit/20-deep end-of-file mode and
// 32-bit/300-deep wrap mode) driven by directed and random stimulus; a reference model
// pushes expected outputs into a scoreboard that a separate monitor pops after each edge.
module tb_xillybus_mem_port;
   localparam int DW0 = 8;
   localparam int AW0 = 5;
   localparam int D0  = 20;
   localparam int W0  = 0;
   localparam int DW1 = 32;
   localparam int AW1 = 9;
   localparam int D1  = 300;
   localparam int W1  = 1;
   localparam int MD  = 300;

   typedef struct {
      bit          upd;
      int          addr;
      bit          wren;
      logic [31:0] wdata;
      bit          rden;
      bit          wopen;
      bit          ropen;
      bit          app_en;
      bit          app_we;
      int          app_addr;
      logic [31:0] app_wdata;
      bit          dclr;
      bit          eclr;
   } stim_t;

   typedef struct {
      int          cyc;
      int          inst;
      logic [31:0] rd;
      logic [31:0] ard;
      bit          coll;
      bit          dirty;
      bit          full;
      bit [1:0]    err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   exp_t sbq[$];

   // Reference model state per instance
   logic [31:0] m_mem [2][MD];
   int          m_ptr [2];
   logic [31:0] m_rd [2];
   logic [31:0] m_ard [2];
   bit          m_coll [2];
   bit          m_dirty [2];
   bit [1:0]    m_err [2];
   bit          m_wo [2];
   bit          m_ro [2];

   always #5 clk = ~clk;

   xillybus_mem_port_if #(.DATA_W(DW0), .ADDR_W(AW0)) if0 ();
   xillybus_mem_port_if #(.DATA_W(DW1), .ADDR_W(AW1)) if1 ();

   xillybus_mem_port #(.DATA_W(DW0), .ADDR_W(AW0), .DEPTH(D0), .WRAP(W0)) dut0 (
      .bus_clk_w(clk),
      .bus_rst_w(rst),
      .bus(if0)
   );

   xillybus_mem_port #(.DATA_W(DW1), .ADDR_W(AW1), .DEPTH(D1), .WRAP(W1)) dut1 (
      .bus_clk_w(clk),
      .bus_rst_w(rst),
      .bus(if1)
   );

   function automatic int dep(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   function automatic bit wrp(input int i);
      return (i == 0) ? (W0 != 0) : (W1 != 0);
   endfunction

   function automatic logic [31:0] msk(input int i);
      return (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
   endfunction

   function automatic stim_t z();
      stim_t s;
      s.upd = 0; s.addr = 0; s.wren = 0; s.wdata = '0; s.rden = 0; s.wopen = 0; s.ropen = 0;
      s.app_en = 0; s.app_we = 0; s.app_addr = 0; s.app_wdata = '0; s.dclr = 0; s.eclr = 0;
      return s;
   endfunction

   function automatic stim_t sk(input int a);
      stim_t s;
      s = z();
      s.upd = 1;
      s.addr = a;
      return s;
   endfunction

   function automatic stim_t rnd(input int i);
      stim_t s;
      s = z();
      s.upd       = ($urandom_range(0, 99) < 15);
      s.addr      = $urandom_range(0, dep(i) + 3);
      s.wren      = ($urandom_range(0, 99) < 40);
      s.wdata     = $urandom();
      s.rden      = ($urandom_range(0, 99) < 40);
      s.wopen     = ($urandom_range(0, 19) == 0);
      s.ropen     = ($urandom_range(0, 19) == 0);
      s.app_en    = ($urandom_range(0, 1) == 1);
      s.app_we    = ($urandom_range(0, 1) == 1);
      s.app_addr  = ($urandom_range(0, 1) == 1) ? m_ptr[i] : $urandom_range(0, dep(i) + 3);
      s.app_wdata = $urandom();
      s.dclr      = ($urandom_range(0, 9) == 0);
      s.eclr      = ($urandom_range(0, 9) == 0);
      return s;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cyc %0d: got %h want %h", nm, i, cyc, act, exp);
      end
   endtask

   task automatic apply(input int i, input stim_t s);
      if (i == 0) begin
         if0.user_mem_addr_update_w = s.upd;
         if0.user_mem_addr_w        = AW0'(s.addr);
         if0.user_w_mem_wren_w      = s.wren;
         if0.user_w_mem_data_w      = s.wdata[DW0-1:0];
         if0.user_w_mem_open_w      = s.wopen;
         if0.user_r_mem_rden_w      = s.rden;
         if0.user_r_mem_open_w      = s.ropen;
         if0.app_en                 = s.app_en;
         if0.app_we                 = s.app_we;
         if0.app_addr               = AW0'(s.app_addr);
         if0.app_wdata              = s.app_wdata[DW0-1:0];
         if0.app_dirty_clr          = s.dclr;
         if0.err_clr                = s.eclr;
      end else begin
         if1.user_mem_addr_update_w = s.upd;
         if1.user_mem_addr_w        = AW1'(s.addr);
         if1.user_w_mem_wren_w      = s.wren;
         if1.user_w_mem_data_w      = s.wdata[DW1-1:0];
         if1.user_w_mem_open_w      = s.wopen;
         if1.user_r_mem_rden_w      = s.rden;
         if1.user_r_mem_open_w      = s.ropen;
         if1.app_en                 = s.app_en;
         if1.app_we                 = s.app_we;
         if1.app_addr               = AW1'(s.app_addr);
         if1.app_wdata              = s.app_wdata[DW1-1:0];
         if1.app_dirty_clr          = s.dclr;
         if1.err_clr                = s.eclr;
      end
   endtask

   task automatic sample(input int i, output logic [31:0] rd, output logic [31:0] ard,
                         output logic [31:0] coll, output logic [31:0] dirty,
                         output logic [31:0] full, output logic [31:0] empty,
                         output logic [31:0] eof, output logic [31:0] err);
      if (i == 0) begin
         rd = 32'(if0.user_r_mem_data_w); ard = 32'(if0.app_rdata);
         coll = 32'(if0.app_collision); dirty = 32'(if0.app_dirty);
         full = 32'(if0.user_w_mem_full_w); empty = 32'(if0.user_r_mem_empty_w);
         eof = 32'(if0.user_r_mem_eof_w); err = 32'(if0.err_flags);
      end else begin
         rd = 32'(if1.user_r_mem_data_w); ard = 32'(if1.app_rdata);
         coll = 32'(if1.app_collision); dirty = 32'(if1.app_dirty);
         full = 32'(if1.user_w_mem_full_w); empty = 32'(if1.user_r_mem_empty_w);
         eof = 32'(if1.user_r_mem_eof_w); err = 32'(if1.err_flags);
      end
   endtask

   // Behavioural model of one clock edge; pushes the expected post-edge outputs
   task automatic model(input int i, input stim_t s);
      int   d, tgt, ea;
      bit   w, orise, sbad, wacc, racc, aw, coll;
      exp_t e;
      d     = dep(i);
      w     = wrp(i);
      orise = (s.wopen && !m_wo[i]) || (s.ropen && !m_ro[i]);
      sbad  = s.upd && (s.addr >= d);
      tgt   = sbad ? (w ? 0 : d) : s.addr;
      ea    = s.upd ? tgt : (orise ? 0 : m_ptr[i]);
      wacc  = s.wren && (ea < d);
      racc  = s.rden && (ea < d);
      aw    = s.app_en && s.app_we && (s.app_addr < d);
      coll  = aw && wacc && (s.app_addr == ea);
      if (racc) m_rd[i] = m_mem[i][ea];
      if (s.app_en && !s.app_we) m_ard[i] = (s.app_addr < d) ? m_mem[i][s.app_addr] : 32'h0;
      if (aw && !coll) m_mem[i][s.app_addr] = s.app_wdata & msk(i);
      if (wacc) m_mem[i][ea] = s.wdata & msk(i);
      if (wacc || racc) m_ptr[i] = (ea == d - 1) ? (w ? 0 : d) : ea + 1;
      else if (s.upd) m_ptr[i] = tgt;
      else if (orise) m_ptr[i] = 0;
      m_err[i]   = (s.eclr ? 2'b00 : m_err[i]) | {s.rden && !racc, sbad || (s.wren && !wacc)};
      m_dirty[i] = wacc ? 1'b1 : (s.dclr ? 1'b0 : m_dirty[i]);
      m_coll[i]  = coll;
      m_wo[i]    = s.wopen;
      m_ro[i]    = s.ropen;
      e.cyc = cyc; e.inst = i; e.rd = m_rd[i]; e.ard = m_ard[i]; e.coll = m_coll[i];
      e.dirty = m_dirty[i]; e.full = !w && (m_ptr[i] == d); e.err = m_err[i];
      sbq.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ptr[i] = 0; m_rd[i] = '0; m_ard[i] = '0; m_coll[i] = 0;
         m_dirty[i] = 0; m_err[i] = 2'b00; m_wo[i] = 0; m_ro[i] = 0;
      end
   endtask

   task automatic step(input int i, input stim_t s);
      @(negedge clk);
      apply(i, s);
      apply(1 - i, z());
      model(i, s);
      model(1 - i, z());
   endtask

   task automatic check_reset();
      logic [31:0] rd, ard, coll, dirty, full, empty, eof, err;
      for (int i = 0; i < 2; i++) begin
         sample(i, rd, ard, coll, dirty, full, empty, eof, err);
         chk("rst_rdata", i, rd, 32'h0);
         chk("rst_app_rdata", i, ard, 32'h0);
         chk("rst_collision", i, coll, 32'h0);
         chk("rst_dirty", i, dirty, 32'h0);
         chk("rst_full", i, full, 32'h0);
         chk("rst_empty", i, empty, 32'h0);
         chk("rst_eof", i, eof, 32'h0);
         chk("rst_err", i, err, 32'h0);
      end
   endtask

   // Asynchronous assertion between edges; outputs must clear before any clock edge
   task automatic do_reset();
      @(negedge clk);
      apply(0, z());
      apply(1, z());
      #3 rst = 1'b1;
      #1 check_reset();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t        e;
      logic [31:0] rd, ard, coll, dirty, full, empty, eof, err;
      forever begin
         @(posedge clk);
         #1;
         while (sbq.size() > 0) begin
            if (sbq[0].cyc > cyc) break;
            e = sbq.pop_front();
            sample(e.inst, rd, ard, coll, dirty, full, empty, eof, err);
            chk("rdata", e.inst, rd, e.rd);
            chk("app_rdata", e.inst, ard, e.ard);
            chk("collision", e.inst, coll, 32'(e.coll));
            chk("dirty", e.inst, dirty, 32'(e.dirty));
            chk("full", e.inst, full, 32'(e.full));
            chk("empty", e.inst, empty, 32'(e.full));
            chk("eof", e.inst, eof, 32'(e.full));
            chk("err_flags", e.inst, err, 32'(e.err));
         end
         cyc++;
      end
   end

   initial begin : driver
      stim_t s;
      apply(0, z());
      apply(1, z());
      #1 rst = 1'b1;
      #1 check_reset();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Fill both arrays through the application port so every word is defined
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < dep(i); a++) begin
            s = z(); s.app_en = 1; s.app_we = 1; s.app_addr = a; s.app_wdata = $urandom();
            step(i, s);
         end
      end

      // Seek 3, write two words, seek back and read them in order
      for (int i = 0; i < 2; i++) begin
         step(i, sk(3));
         s = z(); s.wren = 1; s.wdata = 32'hA5; step(i, s);
         s.wdata = 32'h5A; step(i, s);
         step(i, sk(3));
         s = z(); s.rden = 1; step(i, s);
         step(i, s);
         step(i, z());
      end

      // Wrap mode: second write past the last word lands at address 0
      step(1, sk(D1 - 1));
      s = z(); s.wren = 1; s.wdata = 32'h1234_5678; step(1, s);
      s.wdata = 32'h9ABC_DEF0; step(1, s);
      step(1, sk(0));
      s = z(); s.rden = 1; step(1, s);
      step(1, sk(D1 - 1));
      step(1, s);

      // End-of-file mode: fill to end, rejected write then read, seek back clears status
      step(0, sk(D0 - 1));
      s = z(); s.wren = 1; s.wdata = 32'h77; step(0, s);
      s.wdata = 32'h78; step(0, s);
      s = z(); s.rden = 1; step(0, s);
      step(0, sk(0));
      s = z(); s.eclr = 1; step(0, s);

      // Seek with write in one cycle, then read-before-write at the same address
      s = sk(7); s.wren = 1; s.wdata = 32'h11; step(0, s);
      s = sk(8); s.wren = 1; s.wdata = 32'h22; step(0, s);
      step(0, sk(8));
      s = z(); s.rden = 1; s.wren = 1; s.wdata = 32'h33; step(0, s);
      step(0, sk(8));
      s = z(); s.rden = 1; step(0, s);

      // Host and application write the same address together
      s = sk(10); s.wren = 1; s.wdata = 32'h44;
      s.app_en = 1; s.app_we = 1; s.app_addr = 10; s.app_wdata = 32'h99;
      step(0, s);
      step(0, z());
      s = z(); s.app_en = 1; s.app_addr = 10; step(0, s);
      s = z(); s.app_en = 1; s.app_addr = 22; step(0, s);

      // Open edges rewind the pointer; a simultaneous seek overrides
      step(0, sk(5));
      s = z(); s.wopen = 1; step(0, s);
      s.rden = 1; step(0, s);
      step(0, z());
      s = sk(6); s.ropen = 1; step(0, s);
      s = z(); s.rden = 1; step(0, s);

      // Reset mid-stream with the pointer at 12 and flags set; RAM survives
      step(0, sk(25));
      step(0, sk(12));
      s = z(); s.app_en = 1; s.app_addr = 3; step(0, s);
      s = z(); s.rden = 1; step(0, s);
      step(0, sk(12));
      do_reset();
      s = z(); s.app_en = 1; s.app_addr = 10; step(0, s);
      s = z(); s.rden = 1; step(0, s);
      step(0, z());

      // Random traffic
      for (int i = 0; i < 2; i++) begin
         repeat (400) step(i, rnd(i));
      end
      repeat (3) step(0, z());

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 0, 32'(sbq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
